// File: rtl/bus_mem_pkg.sv
// bus_mem_pkg: shared state encoding and default addresses for bus_mem_responder
package bus_mem_pkg;
  typedef enum logic [1:0] {LOAD, HOLD, RUN} state_t;
  localparam logic [15:0] DEF_LOAD_BASE = 16'h0000;
  localparam logic [15:0] DEF_DBG_ADDR  = 16'hFFF0;
endpackage

// File: rtl/resp_ram.sv
// resp_ram: byte RAM with one synchronous write port and one asynchronous read port
module resp_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (wen) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: 6502-side RAM with boot loader, CPU reset sequencing and debug byte port
module bus_mem_responder
  import bus_mem_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter logic [15:0] LOAD_BASE  = DEF_LOAD_BASE,
  parameter int          RESET_HOLD = 2,
  parameter logic [15:0] DBG_ADDR   = DEF_DBG_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ab,
  input  logic [7:0]  cpu_do,
  input  logic        we,
  output logic [7:0]  di,
  output logic        cpu_reset,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        dbg_valid,
  output logic [7:0]  dbg_data
);
  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic [3:0]        cnt, cnt_n;
  logic              ld_fire, cpu_wr;
  logic [7:0]        rdata;
  assign ld_ready  = (state == LOAD) & reset_n;
  assign cpu_reset = state != RUN;
  assign ld_fire   = ld_valid & ld_ready;
  assign cpu_wr    = (state == RUN) & we;
  assign di        = cpu_wr ? 8'h00 : rdata;
  resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .wen   (ld_fire | cpu_wr),
    .waddr (ld_fire ? ptr : ab[ADDR_W-1:0]),
    .wdata (ld_fire ? ld_data : cpu_do),
    .raddr (ab[ADDR_W-1:0]),
    .rdata (rdata)
  );
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    if (ld_fire) begin
      ptr_n = ptr + 1'b1;
      if (ld_last) begin
        state_n = HOLD;
        cnt_n   = '0;
      end
    end
    if (state == HOLD) begin
      cnt_n   = cnt + 1'b1;
      state_n = (cnt == 4'(RESET_HOLD - 1)) ? RUN : HOLD;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LOAD;
      ptr       <= LOAD_BASE[ADDR_W-1:0];
      cnt       <= '0;
      dbg_valid <= 1'b0;
      dbg_data  <= 8'h00;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      dbg_valid <= cpu_wr && (ab == DBG_ADDR);
      if (cpu_wr && (ab == DBG_ADDR)) dbg_data <= cpu_do;
    end
  end
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed checks of loader, reset hold, CPU read/write and debug port
module tb_bus_mem_responder;
  logic        clk = 0;
  logic        reset_n, reset_n_b;
  logic [15:0] ab;
  logic [7:0]  cpu_do;
  logic        we;
  logic [7:0]  di, di_b;
  logic        cpu_reset, cpu_reset_b;
  logic        ld_valid, ld_last, ld_valid_b, ld_last_b;
  logic [7:0]  ld_data, ld_data_b;
  logic        ld_ready, ld_ready_b;
  logic        dbg_valid, dbg_valid_b;
  logic [7:0]  dbg_data, dbg_data_b;
  int          pass_cnt = 0;
  int          total = 0;
  logic [7:0]  img [10] = '{8'hA2, 8'h05, 8'hA0, 8'h0B, 8'hBD, 8'hFE, 8'h05, 8'h99, 8'hFE, 8'h05};
  logic [7:0]  img_b [3] = '{8'hAA, 8'hBB, 8'hCC};

  always #5 clk = ~clk;

  bus_mem_responder dut (
    .clk(clk), .reset_n(reset_n), .ab(ab), .cpu_do(cpu_do), .we(we), .di(di),
    .cpu_reset(cpu_reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .dbg_valid(dbg_valid), .dbg_data(dbg_data)
  );

  bus_mem_responder #(.LOAD_BASE(16'hFFFE)) dut_b (
    .clk(clk), .reset_n(reset_n_b), .ab(ab), .cpu_do(cpu_do), .we(we), .di(di_b),
    .cpu_reset(cpu_reset_b), .ld_valid(ld_valid_b), .ld_data(ld_data_b), .ld_last(ld_last_b),
    .ld_ready(ld_ready_b), .dbg_valid(dbg_valid_b), .dbg_data(dbg_data_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 0; reset_n_b = 0; ab = 0; cpu_do = 0; we = 0;
    ld_valid = 0; ld_data = 0; ld_last = 0;
    ld_valid_b = 0; ld_data_b = 0; ld_last_b = 0;
    #1;
    chk("rst_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    chk("rst_ld_ready", {7'b0, ld_ready}, 8'h00);
    chk("rst_dbg_valid", {7'b0, dbg_valid}, 8'h00);
    chk("rst_dbg_data", dbg_data, 8'h00);
    tick;
    reset_n = 1; reset_n_b = 1;
    #1;
    chk("load_ld_ready", {7'b0, ld_ready}, 8'h01);
    chk("load_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    // image into dut, 3-byte wrap image into dut_b in parallel
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1; ld_data = img[i]; ld_last = (i == 9);
      ld_valid_b = (i < 3); ld_data_b = (i < 3) ? img_b[i] : 8'h00; ld_last_b = (i == 2);
      we = (i == 4); ab = 16'h0100; cpu_do = 8'h66;
      tick;
    end
    ld_valid = 0; ld_last = 0; ld_valid_b = 0; ld_last_b = 0; we = 0;
    #1;
    chk("hold0_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    chk("hold0_ld_ready", {7'b0, ld_ready}, 8'h00);
    tick;
    chk("hold1_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    tick;
    chk("run_cpu_reset", {7'b0, cpu_reset}, 8'h00);
    chk("run_ld_ready", {7'b0, ld_ready}, 8'h00);
    ab = 16'h0004; #1; chk("rd_0004", di, 8'hBD);
    ab = 16'h0009; #1; chk("rd_0009", di, 8'h05);
    ab = 16'h0000; #1; chk("rd_0000", di, 8'hA2);
    chk("wrap_0000", di_b, 8'hCC);
    ab = 16'hFFFE; #1; chk("wrap_FFFE", di_b, 8'hAA);
    ab = 16'hFFFF; #1; chk("wrap_FFFF", di_b, 8'hBB);
    chk("b_cpu_reset", {7'b0, cpu_reset_b}, 8'h00);
    // CPU write then read-back
    tick;
    we = 1; ab = 16'h0609; cpu_do = 8'h16; #1;
    chk("wr_di_zero", di, 8'h00);
    tick;
    we = 0; #1;
    chk("rd_after_wr", di, 8'h16);
    // loader bytes must be dropped in RUN
    we = 1; ab = 16'h000A; cpu_do = 8'h5A;
    tick;
    we = 0; ld_valid = 1; ld_data = 8'h77;
    tick;
    ld_valid = 0; #1;
    chk("run_ld_dropped", di, 8'h5A);
    // debug port
    we = 1; ab = 16'hFFF0; cpu_do = 8'h41; #1;
    chk("dbg_pre", {7'b0, dbg_valid}, 8'h00);
    tick;
    we = 0; #1;
    chk("dbg_pulse", {7'b0, dbg_valid}, 8'h01);
    chk("dbg_data", dbg_data, 8'h41);
    chk("dbg_ram", di, 8'h41);
    tick;
    chk("dbg_one_cycle", {7'b0, dbg_valid}, 8'h00);
    chk("dbg_held", dbg_data, 8'h41);
    we = 1; ab = 16'hFFF0; cpu_do = 8'h42;
    tick;
    cpu_do = 8'h43; #1;
    chk("b2b_pulse1", {7'b0, dbg_valid}, 8'h01);
    chk("b2b_data1", dbg_data, 8'h42);
    tick;
    ab = 16'h7FF0; cpu_do = 8'h99; #1;
    chk("b2b_pulse2", {7'b0, dbg_valid}, 8'h01);
    chk("b2b_data2", dbg_data, 8'h43);
    tick;
    we = 0; #1;
    chk("non_dbg_addr", {7'b0, dbg_valid}, 8'h00);
    chk("non_dbg_data", dbg_data, 8'h43);
    // reset mid-run with a pulse pending
    we = 1; ab = 16'hFFF0; cpu_do = 8'h55;
    tick;
    we = 0; #1;
    chk("pre_rst_pulse", {7'b0, dbg_valid}, 8'h01);
    reset_n = 0; #1;
    chk("runrst_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    chk("runrst_dbg_valid", {7'b0, dbg_valid}, 8'h00);
    chk("runrst_dbg_data", dbg_data, 8'h00);
    tick;
    reset_n = 1;
    // gapped load from LOAD_BASE, then reset mid-load
    ld_valid = 1; ld_data = 8'h11; tick;
    ld_valid = 0; ld_data = 8'hEE; #1;
    chk("gap_ld_ready", {7'b0, ld_ready}, 8'h01);
    tick;
    tick;
    ld_valid = 1; ld_data = 8'h22; tick;
    ld_data = 8'h33; tick;
    ld_valid = 0; reset_n = 0; #1;
    chk("ldrst_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    chk("ldrst_ld_ready", {7'b0, ld_ready}, 8'h00);
    tick;
    reset_n = 1;
    ld_valid = 1; ld_data = 8'h44; ld_last = 1; tick;
    ld_valid = 0; ld_last = 0;
    tick;
    tick;
    chk("reload_cpu_reset", {7'b0, cpu_reset}, 8'h00);
    ab = 16'h0000; #1; chk("reload_base", di, 8'h44);
    ab = 16'h0001; #1; chk("gap_ram1", di, 8'h22);
    ab = 16'h0002; #1; chk("gap_ram2", di, 8'h33);
    ab = 16'h0004; #1; chk("partial_kept", di, 8'hBD);
    ab = 16'h0609; #1; chk("ram_kept_0609", di, 8'h16);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
